// File: rtl/user_mem_pkg.sv
// Shared encodings and defaults for the user-project BRAM arbiter.
package user_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_DMA
    } grant_t;

    localparam int ADDR_W_DEF      = 10;
    localparam int BRAM_DELAYS_DEF = 10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; remembers the last grant it issued.
module rr_arbiter2
    import user_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   req_cpu,
    input  logic   req_dma,
    output logic   valid,
    output grant_t grant
);

    grant_t last_grant;

    always_comb begin
        valid = req_cpu | req_dma;
        grant = GNT_CPU;
        if (req_cpu & req_dma)
            grant = (last_grant == GNT_CPU) ? GNT_DMA : GNT_CPU;
        else if (req_dma)
            grant = GNT_DMA;
    end

    // Reset to DMA so the CPU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= GNT_DMA;
        else if (en & valid)
            last_grant <= grant;
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Arbitrates CPU and DMA Wishbone requests onto one fixed-latency BRAM port.
module wb_mem_arbiter
    import user_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DELAYS = BRAM_DELAYS_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cpu_stb_i,
    input  logic              cpu_cyc_i,
    input  logic              cpu_we_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [31:0]       cpu_adr_i,
    input  logic [31:0]       cpu_dat_i,
    output logic              cpu_ack_o,
    output logic [31:0]       cpu_dat_o,
    input  logic              dma_stb_i,
    input  logic              dma_cyc_i,
    input  logic              dma_we_i,
    input  logic [3:0]        dma_sel_i,
    input  logic [31:0]       dma_adr_i,
    input  logic [31:0]       dma_dat_i,
    output logic              dma_ack_o,
    output logic [31:0]       dma_dat_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [31:0]       mem_wdat_o,
    input  logic [31:0]       mem_rdat_i
);

    localparam int CNT_W = $clog2(DELAYS) + 1;

    state_t           state;
    grant_t           gnt;
    grant_t           arb_gnt;
    logic             arb_valid;
    logic             lat_we;
    logic             abort;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      data_q;

    logic             req_cpu;
    logic             req_dma;
    logic             sel_we;
    logic [3:0]       sel_sel;
    logic [31:0]      sel_adr;
    logic [31:0]      sel_dat;
    logic             cyc_g;
    logic             done;
    logic             resp;
    logic [31:0]      resp_dat;
    logic             unused_adr;

    assign req_cpu = cpu_stb_i & cpu_cyc_i;
    assign req_dma = dma_stb_i & dma_cyc_i;

    rr_arbiter2 u_arb (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .en      (state == IDLE),
        .req_cpu (req_cpu),
        .req_dma (req_dma),
        .valid   (arb_valid),
        .grant   (arb_gnt)
    );

    assign sel_we     = (arb_gnt == GNT_DMA) ? dma_we_i  : cpu_we_i;
    assign sel_sel    = (arb_gnt == GNT_DMA) ? dma_sel_i : cpu_sel_i;
    assign sel_adr    = (arb_gnt == GNT_DMA) ? dma_adr_i : cpu_adr_i;
    assign sel_dat    = (arb_gnt == GNT_DMA) ? dma_dat_i : cpu_dat_i;
    assign unused_adr = ^{sel_adr[31:ADDR_W+2], sel_adr[1:0]};

    // A master that drops cyc mid-access loses its ack but the access completes.
    assign cyc_g    = (gnt == GNT_DMA) ? dma_cyc_i : cpu_cyc_i;
    assign done     = ((state == ACCESS) & lat_we)
                    | ((state == WAIT) & (cnt == '0));
    assign resp     = done & ~abort & cyc_g;
    assign resp_dat = (state == WAIT) ? mem_rdat_i : data_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            gnt        <= GNT_CPU;
            lat_we     <= 1'b0;
            abort      <= 1'b0;
            cnt        <= '0;
            data_q     <= '0;
            mem_en_o   <= 1'b0;
            mem_we_o   <= '0;
            mem_adr_o  <= '0;
            mem_wdat_o <= '0;
            cpu_ack_o  <= 1'b0;
            dma_ack_o  <= 1'b0;
            cpu_dat_o  <= '0;
            dma_dat_o  <= '0;
        end else begin
            cpu_ack_o <= resp & (gnt == GNT_CPU);
            dma_ack_o <= resp & (gnt == GNT_DMA);
            if (resp & (gnt == GNT_CPU))
                cpu_dat_o <= resp_dat;
            if (resp & (gnt == GNT_DMA))
                dma_dat_o <= resp_dat;

            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        gnt        <= arb_gnt;
                        lat_we     <= sel_we;
                        abort      <= 1'b0;
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= sel_we ? sel_sel : 4'b0;
                        mem_adr_o  <= sel_adr[ADDR_W+1:2];
                        mem_wdat_o <= sel_dat;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en_o <= 1'b0;
                    mem_we_o <= '0;
                    abort    <= ~cyc_g;
                    if (lat_we) begin
                        state <= resp ? RESP : IDLE;
                    end else begin
                        cnt   <= CNT_W'(DELAYS - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    abort <= abort | ~cyc_g;
                    if (cnt == '0) begin
                        data_q <= mem_rdat_i;
                        state  <= resp ? RESP : IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: transaction-timeline model, BRAM models, directed cases.
module tb_wb_mem_arbiter;

    localparam int AW = 10;
    localparam int D  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        cpu_stb, cpu_cyc, cpu_we;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_adr, cpu_dat;
    logic        cpu_ack;
    logic [31:0] cpu_rd;
    logic        dma_stb, dma_cyc, dma_we;
    logic [3:0]  dma_sel;
    logic [31:0] dma_adr, dma_dat;
    logic        dma_ack;
    logic [31:0] dma_rd;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_wdat, mem_rdat;

    wb_mem_arbiter #(.ADDR_W(AW), .DELAYS(D)) dut (
        .wb_clk_i  (clk),     .wb_rst_i  (rst),
        .cpu_stb_i (cpu_stb), .cpu_cyc_i (cpu_cyc), .cpu_we_i (cpu_we),
        .cpu_sel_i (cpu_sel), .cpu_adr_i (cpu_adr), .cpu_dat_i (cpu_dat),
        .cpu_ack_o (cpu_ack), .cpu_dat_o (cpu_rd),
        .dma_stb_i (dma_stb), .dma_cyc_i (dma_cyc), .dma_we_i (dma_we),
        .dma_sel_i (dma_sel), .dma_adr_i (dma_adr), .dma_dat_i (dma_dat),
        .dma_ack_o (dma_ack), .dma_dat_o (dma_rd),
        .mem_en_o  (mem_en),  .mem_we_o  (mem_we),  .mem_adr_o (mem_adr),
        .mem_wdat_o(mem_wdat), .mem_rdat_i(mem_rdat)
    );

    // Second build with single-cycle read latency; CPU reads only.
    logic          c1_stb, c1_cyc;
    logic [31:0]   c1_adr;
    logic          ack1, d1_ack;
    logic [31:0]   rd1, d1_rd;
    logic          m1_en;
    logic [3:0]    m1_we;
    logic [AW-1:0] m1_adr;
    logic [31:0]   m1_wdat, m1_rdat;

    wb_mem_arbiter #(.ADDR_W(AW), .DELAYS(1)) dut1 (
        .wb_clk_i  (clk),     .wb_rst_i  (rst),
        .cpu_stb_i (c1_stb),  .cpu_cyc_i (c1_cyc), .cpu_we_i (1'b0),
        .cpu_sel_i (4'hF),    .cpu_adr_i (c1_adr), .cpu_dat_i (32'h0),
        .cpu_ack_o (ack1),    .cpu_dat_o (rd1),
        .dma_stb_i (1'b0),    .dma_cyc_i (1'b0),   .dma_we_i (1'b0),
        .dma_sel_i (4'h0),    .dma_adr_i (32'h0),  .dma_dat_i (32'h0),
        .dma_ack_o (d1_ack),  .dma_dat_o (d1_rd),
        .mem_en_o  (m1_en),   .mem_we_o  (m1_we),  .mem_adr_o (m1_adr),
        .mem_wdat_o(m1_wdat), .mem_rdat_i(m1_rdat)
    );

    // BRAM models: data appears exactly D cycles after the enable cycle, junk otherwise.
    logic [31:0] bram  [1024];
    logic [31:0] bram1 [1024];
    logic [31:0] rpipe [D];
    logic [31:0] rp1;

    always @(posedge clk) begin
        for (int i = D - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= mem_en ? bram[mem_adr] : (32'hBAD0_0000 | cyc);
        if (mem_en)
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) bram[mem_adr][8*b +: 8] <= mem_wdat[8*b +: 8];
        rp1 <= m1_en ? bram1[m1_adr] : 32'hBAD1_0000;
    end
    assign mem_rdat = rpipe[D-1];
    assign m1_rdat  = rp1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Timeline model: one transaction at a time, access the cycle after grant,
    // completion D cycles later for reads, ack the cycle after completion.
    logic [31:0] shadow [1024];
    bit          busy = 0, aborted = 0, last = 1, g = 0, rc, rd;
    int          t_acc, t_done;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat;
    logic          e_en = 0, e_cack = 0, e_dack = 0;
    logic [3:0]    e_we = 0;
    logic [AW-1:0] e_adr = 0;
    logic [31:0]   e_wdat = 0, e_cdat = 0, e_ddat = 0, e_data = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy = 0; last = 1; aborted = 0;
            e_en = 0; e_cack = 0; e_dack = 0;
            e_cdat = 0; e_ddat = 0; e_data = 0;
        end else begin
            e_en = 0; e_cack = 0; e_dack = 0;
            if (!busy) begin
                rc = cpu_stb & cpu_cyc;
                rd = dma_stb & dma_cyc;
                if (rc | rd) begin
                    g = (rc & rd) ? ~last : rd;
                    last = g; busy = 1; aborted = 0;
                    m_we  = g ? dma_we  : cpu_we;
                    m_sel = g ? dma_sel : cpu_sel;
                    m_adr = g ? dma_adr : cpu_adr;
                    m_dat = g ? dma_dat : cpu_dat;
                    t_acc  = cyc + 1;
                    t_done = m_we ? t_acc : t_acc + D;
                    e_en = 1; e_adr = m_adr[AW+1:2];
                    e_we = m_we ? m_sel : 4'h0; e_wdat = m_dat;
                    if (m_we)
                        for (int b = 0; b < 4; b++)
                            if (m_sel[b]) shadow[m_adr[AW+1:2]][8*b +: 8] = m_dat[8*b +: 8];
                end
            end else if (cyc == t_done + 1) begin
                busy = 0;
            end else begin
                if (!(g ? dma_cyc : cpu_cyc)) aborted = 1;
                if (cyc == t_done) begin
                    if (!m_we) e_data = shadow[m_adr[AW+1:2]];
                    if (aborted) busy = 0;
                    else if (g) begin e_dack = 1; e_ddat = e_data; end
                    else begin e_cack = 1; e_cdat = e_data; end
                end
            end
        end
    end

    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("mem_en", mem_en, e_en);
            chk("cpu_ack", cpu_ack, e_cack);
            chk("dma_ack", dma_ack, e_dack);
            chk("cpu_dat", cpu_rd, e_cdat);
            chk("dma_dat", dma_rd, e_ddat);
            if (e_en) begin
                chk("mem_adr", mem_adr, e_adr);
                chk("mem_we", mem_we, e_we);
                chk("mem_wdat", mem_wdat, e_wdat);
            end
        end
    end

    int          en_cyc = 0, dack_cnt = 0;
    logic [AW-1:0] en_adr = 0;
    logic [3:0]  en_we = 0;
    bit          ord [$];
    always @(negedge clk) begin
        if (mem_en) begin en_cyc = cyc; en_adr = mem_adr; en_we = mem_we; end
        if (dma_ack) dack_cnt++;
        if (cpu_ack) ord.push_back(1'b0);
        if (dma_ack) ord.push_back(1'b1);
    end

    task automatic drive(input bit m, input bit on, input bit we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (m) begin
            dma_stb = on; dma_cyc = on; dma_we = we;
            dma_sel = sel; dma_adr = adr; dma_dat = dat;
        end else begin
            cpu_stb = on; cpu_cyc = on; cpu_we = we;
            cpu_sel = sel; cpu_adr = adr; cpu_dat = dat;
        end
    endtask

    task automatic run(input bit m, input bit we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat,
                       output int lat, output int t0);
        @(posedge clk); #1;
        drive(m, 1'b1, we, sel, adr, dat);
        t0 = cyc; lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((m ? dma_ack : cpu_ack) === 1'b1) begin lat = cyc - t0; break; end
        end
        drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic hold_master(input bit m, input int t0, output int first);
        int n = 0;
        first = -1;
        for (int k = 0; k < 80 && n < 2; k++) begin
            @(negedge clk);
            if ((m ? dma_ack : cpu_ack) === 1'b1) begin
                if (n == 0) first = cyc - t0;
                n++;
            end
        end
        drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    int lat, t0, d0, cf, df, ca, prev, n1;
    logic [3:0] seq;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        c1_stb = 0; c1_cyc = 0; c1_adr = 0;
        for (int i = 0; i < 1024; i++) begin
            bram[i]   = {16'hC0DE, 6'd0, i[9:0]};
            shadow[i] = {16'hC0DE, 6'd0, i[9:0]};
            bram1[i]  = 32'hA000_0000 + i;
        end
        bram[16] = 32'hDEADBEEF; shadow[16] = 32'hDEADBEEF;
        bram[64] = 32'hAABBCCDD; shadow[64] = 32'hAABBCCDD;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 4'h0);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_dma_ack", dma_ack, 1'b0);
        chk("rst_cpu_dat", cpu_rd, 32'h0);
        chk("rst_dma_dat", dma_rd, 32'h0);
        rst = 0;
        chk_on = 1;

        // CPU read of word 16
        d0 = dack_cnt;
        run(1'b0, 1'b0, 4'hF, 32'h3800_0040, 32'h0, lat, t0);
        chk("t1_lat", lat, 12);
        chk("t1_en_cyc", en_cyc - t0, 1);
        chk("t1_en_adr", en_adr, 16);
        chk("t1_dat", cpu_rd, 32'hDEADBEEF);
        chk("t1_no_dma_ack", dack_cnt - d0, 0);

        // DMA halfword write then read-back
        run(1'b1, 1'b1, 4'b0011, 32'h3800_0100, 32'h1234_5678, lat, t0);
        chk("t2_wr_lat", lat, 2);
        chk("t2_en_cyc", en_cyc - t0, 1);
        chk("t2_en_we", en_we, 4'b0011);
        chk("t2_en_adr", en_adr, 64);
        run(1'b1, 1'b0, 4'hF, 32'h3800_0100, 32'h0, lat, t0);
        chk("t2_rd_lat", lat, 12);
        chk("t2_rd_dat", dma_rd, 32'hAABB5678);

        // Simultaneous reads held for two transactions each
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h3800_0040, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h3800_0100, 32'h0);
        t0 = cyc;
        ord.delete();
        fork
            hold_master(1'b0, t0, cf);
            hold_master(1'b1, t0, df);
        join
        chk("t3_cpu_first", cf, 12);
        chk("t3_dma_first", df, 25);
        seq = 4'b1111;
        for (int i = 0; i < 4 && i < ord.size(); i++) seq[3-i] = ord[i];
        chk("t3_order", seq, 4'b0101);

        // DMA read aborted during WAIT while CPU waits
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h3800_0100, 32'h0);
        t0 = cyc; d0 = dack_cnt; ca = -1;
        repeat (6) @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h3800_0100, 32'h0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin ca = cyc - t0; break; end
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("t4_cpu_ack_cyc", ca, 24);
        chk("t4_no_dma_ack", dack_cnt - d0, 0);
        chk("t4_cpu_dat", cpu_rd, 32'hAABB5678);

        // DMA write aborted during ACCESS still commits
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h3800_0200, 32'hCAFEF00D);
        d0 = dack_cnt;
        repeat (2) @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (6) @(negedge clk);
        chk("t5_no_ack", dack_cnt - d0, 0);
        chk("t5_en_we", en_we, 4'hF);
        run(1'b0, 1'b0, 4'hF, 32'h3800_0200, 32'h0, lat, t0);
        chk("t5_rd_lat", lat, 12);
        chk("t5_rd_dat", cpu_rd, 32'hCAFEF00D);

        // Reset during ACCESS drops mem_en at once
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h3800_0040, 32'h0);
        repeat (2) @(negedge clk);
        chk("t6_en_before", mem_en, 1'b1);
        #2 rst = 1; #1;
        chk("t6_en_async", mem_en, 1'b0);
        chk("t6_cpu_dat", cpu_rd, 32'h0);
        chk("t6_dma_dat", dma_rd, 32'h0);
        @(negedge clk); #2 rst = 0;

        // Reset during WAIT, then a fresh read
        repeat (5) @(negedge clk);
        #2 rst = 1; #1;
        chk("t7_en", mem_en, 1'b0);
        chk("t7_cpu_ack", cpu_ack, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk); #2 rst = 0;
        run(1'b0, 1'b0, 4'hF, 32'h3800_0044, 32'h0, lat, t0);
        chk("t7_lat", lat, 12);
        chk("t7_dat", cpu_rd, 32'hC0DE0011);

        // Single-cycle latency build, back-to-back CPU reads
        @(posedge clk); #1;
        c1_stb = 1; c1_cyc = 1; c1_adr = 32'h3800_0040;
        t0 = cyc; prev = t0; n1 = 0;
        for (int k = 0; k < 40 && n1 < 4; k++) begin
            @(negedge clk);
            if (ack1 === 1'b1) begin
                chk(n1 == 0 ? "d1_first" : "d1_gap", cyc - prev, n1 == 0 ? 3 : 4);
                chk("d1_dat", rd1, 32'hA000_0010 + n1);
                prev = cyc; n1++;
                c1_adr = c1_adr + 4;
            end
        end
        c1_stb = 0; c1_cyc = 0;
        chk("d1_count", n1, 4);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
